fsquare_pipe: RTL and testbench

- Pipelined IEEE-754 single-precision squarer, y = x*x. It is the inverse operation of the FPU's table-based square root.
- Sits in the multi-cycle FPU beside the sqrt unit. It is used by the verification/refinement path to square a sqrt result and compare it against the original operand.
- Fully pipelined: 3-cycle latency, one result per cycle, with a global stall.

---
 rtl/fsquare_pipe.sv | 142 ++++++++++++++
 tb/tb_fsquare_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fsquare_pipe.sv
// Three-stage IEEE-754 single-precision squarer (y = x*x) with a global stall.
// Round-half-up, denormals flushed, overflow saturates to +inf.
module fsquare_pipe #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        valid_in,
  input  logic        stall,
  output logic [31:0] y,
  output logic        valid_out,
  output logic        ovf,
  output logic        udf
);

  typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} cls_e;

  if (LATENCY != 3) begin : g_bad_latency
    $fatal(1, "fsquare_pipe: LATENCY must be 3");
  end

  // Stage 0 state
  logic [7:0]  r0_ex;
  logic [23:0] r0_m;
  cls_e        r0_cls;
  logic        r0_vld;
  // Stage 1 state
  logic [47:0]        r1_p;
  logic signed [9:0]  r1_e0;
  cls_e               r1_cls;
  logic               r1_vld;
  // Stage 2 state
  logic [31:0] r2_y;
  logic        r2_ovf;
  logic        r2_udf;
  logic        r2_vld;

  cls_e              w_cls;
  logic [47:0]       w_m48;
  logic              w_hi;
  logic [22:0]       w_frac;
  logic              w_rnd;
  logic [23:0]       w_sum;
  logic signed [9:0] w_e1;
  logic signed [9:0] w_e;
  logic [31:0]       w_y;
  logic              w_ovf;
  logic              w_udf;
  logic              w_unused;

  // Sign bit and the product bits below the round position never matter.
  assign w_unused = ^{x[31], r1_p[21:0]};

  always_comb begin
    w_cls = ClsNorm;
    if (x[30:23] == 8'hFF) begin
      w_cls = (x[22:0] != 23'd0) ? ClsNan : ClsInf;
    end else if (x[30:23] == 8'h00) begin
      w_cls = ClsZero;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r0_ex  <= 8'd0;
      r0_m   <= 24'd0;
      r0_cls <= ClsZero;
      r0_vld <= 1'b0;
    end else if (!stall) begin
      r0_ex  <= x[30:23];
      r0_m   <= {1'b1, x[22:0]};
      r0_cls <= w_cls;
      r0_vld <= valid_in;
    end
  end

  assign w_m48 = {24'd0, r0_m};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r1_p   <= 48'd0;
      r1_e0  <= 10'sd0;
      r1_cls <= ClsZero;
      r1_vld <= 1'b0;
    end else if (!stall) begin
      r1_p   <= w_m48 * w_m48;
      r1_e0  <= $signed({1'b0, r0_ex, 1'b0}) - 10'sd127;
      r1_cls <= r0_cls;
      r1_vld <= r0_vld;
    end
  end

  always_comb begin
    w_hi   = r1_p[47];
    w_frac = w_hi ? r1_p[46:24] : r1_p[45:23];
    w_rnd  = w_hi ? r1_p[23] : r1_p[22];
    w_e1   = r1_e0 + (w_hi ? 10'sd1 : 10'sd0);
    w_sum  = {1'b0, w_frac} + {23'd0, w_rnd};
    // A rounding carry leaves w_sum[22:0] all zero, which is the required fraction.
    w_e    = w_sum[23] ? (w_e1 + 10'sd1) : w_e1;
    w_y    = 32'd0;
    w_ovf  = 1'b0;
    w_udf  = 1'b0;
    unique case (r1_cls)
      ClsNan:  w_y = 32'h7FC0_0000;
      ClsInf:  w_y = 32'h7F80_0000;
      ClsZero: w_y = 32'h0000_0000;
      ClsNorm: begin
        if (w_e >= 10'sd255) begin
          w_y   = 32'h7F80_0000;
          w_ovf = 1'b1;
        end else if (w_e <= 10'sd0) begin
          w_y   = 32'h0000_0000;
          w_udf = 1'b1;
        end else begin
          w_y = {1'b0, w_e[7:0], w_sum[22:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r2_y   <= 32'd0;
      r2_ovf <= 1'b0;
      r2_udf <= 1'b0;
      r2_vld <= 1'b0;
    end else if (!stall) begin
      r2_y   <= w_y;
      r2_ovf <= w_ovf & r1_vld;
      r2_udf <= w_udf & r1_vld;
      r2_vld <= r1_vld;
    end
  end

  assign y         = r2_y;
  assign ovf       = r2_ovf;
  assign udf       = r2_udf;
  assign valid_out = r2_vld;

endmodule

// File: tb/tb_fsquare_pipe.sv
// Bench for fsquare_pipe: directed test-plan values, stall and reset scenarios,
// then random traffic scored against an integer-arithmetic reference.
module tb_fsquare_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] x;
  logic        valid_in;
  logic        stall;
  logic [31:0] y;
  logic        valid_out;
  logic        ovf;
  logic        udf;

  int total = 0;
  int bad   = 0;
  int unsigned adv = 0;

  typedef struct {
    logic [33:0] res;  // {ovf, udf, y}
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  logic [34:0] prev;

  always #5 clk = ~clk;

  fsquare_pipe #(.LATENCY(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .x         (x),
    .valid_in  (valid_in),
    .stall     (stall),
    .y         (y),
    .valid_out (valid_out),
    .ovf       (ovf),
    .udf       (udf)
  );

  function automatic logic [33:0] model(input logic [31:0] xv);
    int     ex;
    longint fr;
    longint m;
    longint p;
    longint f;
    longint rnd;
    int     e;
    logic [7:0]  eb;
    logic [22:0] fb;
    ex = int'(xv[30:23]);
    fr = longint'(xv[22:0]);
    if (ex == 255 && fr != 0) return {2'b00, 32'h7FC0_0000};
    if (ex == 255) return {2'b00, 32'h7F80_0000};
    if (ex == 0) return 34'd0;
    m = (64'sd1 << 23) + fr;
    p = m * m;
    e = 2 * ex - 127;
    if (p >= (64'sd1 << 47)) begin
      f   = p >> 24;
      rnd = (p >> 23) & 1;
      e   = e + 1;
    end else begin
      f   = p >> 23;
      rnd = (p >> 22) & 1;
    end
    f = f + rnd;
    if (f >= (64'sd1 << 24)) begin
      f = f >> 1;
      e = e + 1;
    end
    if (e >= 255) return {2'b10, 32'h7F80_0000};
    if (e <= 0) return {2'b01, 32'h0000_0000};
    eb = e[7:0];
    fb = f[22:0];
    return {2'b00, 1'b0, eb, fb};
  endfunction

  task automatic chk(input string tag, input logic [34:0] act, input logic [34:0] expv);
    total++;
    assert (act === expv) else begin
      bad++;
      $error("FAIL %s: observed {vld,ovf,udf,y}=%h expected %h", tag, act, expv);
    end
  endtask

  task automatic check_outputs(input logic stalled);
    logic [34:0] cur;
    exp_t        e;
    cur = {valid_out, ovf, udf, y};
    if (stalled) begin
      chk("stall_hold", cur, prev);
    end else if (q.size() > 0 && q[0].due == adv) begin
      e = q.pop_front();
      chk("result", cur, {1'b1, e.res});
    end else begin
      chk("idle", {valid_out, ovf, udf, 32'd0}, 35'd0);
    end
    prev = cur;
  endtask

  // Drive at the negedge, let one rising edge pass, check at the next negedge.
  task automatic step(input logic v, input logic [31:0] xv, input logic st,
                      input logic [33:0] expv);
    exp_t e;
    valid_in = v;
    x        = xv;
    stall    = st;
    @(posedge clk);
    if (!st) begin
      adv++;
      if (v && rstn) begin
        e.res = expv;
        e.due = adv + 2;
        q.push_back(e);
      end
    end
    @(negedge clk);
    check_outputs(st);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 34'd0);
  endtask

  logic [31:0] dir_x [10] = '{32'h4000_0000, 32'h3FC0_0000, 32'hC040_0000, 32'h3F80_0001,
                             32'h3FFF_FFFF, 32'h7F00_0000, 32'h1F00_0000, 32'h0040_0000,
                             32'h7FC1_2345, 32'hFF80_0000};
  logic [33:0] dir_e [10] = '{{2'b00, 32'h4080_0000}, {2'b00, 32'h4010_0000},
                             {2'b00, 32'h4110_0000}, {2'b00, 32'h3F80_0002},
                             {2'b00, 32'h407F_FFFE}, {2'b10, 32'h7F80_0000},
                             {2'b01, 32'h0000_0000}, {2'b00, 32'h0000_0000},
                             {2'b00, 32'h7FC0_0000}, {2'b00, 32'h7F80_0000}};

  initial begin
    rstn     = 1'b0;
    valid_in = 1'b0;
    stall    = 1'b0;
    x        = 32'd0;
    prev     = 35'd0;
    #3;
    chk("reset_state", {valid_out, ovf, udf, y}, 35'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Test-plan values, back to back.
    for (int i = 0; i < 10; i++) step(1'b1, dir_x[i], 1'b0, dir_e[i]);
    idle(3);

    // Stall: 2.0, 3.0, then four stalled cycles presenting 1.5 (ignored), then 1.5.
    step(1'b1, 32'h4000_0000, 1'b0, {2'b00, 32'h4080_0000});
    step(1'b1, 32'h4040_0000, 1'b0, {2'b00, 32'h4110_0000});
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3FC0_0000, 1'b1, 34'd0);
    step(1'b1, 32'h3FC0_0000, 1'b0, {2'b00, 32'h4010_0000});
    idle(3);
    chk("stall_drained", 35'(q.size()), 35'd0);

    // Asynchronous reset between edges with three operands in flight.
    step(1'b1, 32'h4000_0000, 1'b0, {2'b00, 32'h4080_0000});
    step(1'b1, 32'h4040_0000, 1'b0, {2'b00, 32'h4110_0000});
    step(1'b1, 32'h3FC0_0000, 1'b0, {2'b00, 32'h4010_0000});
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset", {valid_out, ovf, udf, y}, 35'd0);
    q.delete();
    prev = 35'd0;
    idle(1);
    #2;
    rstn = 1'b1;
    @(negedge clk);
    check_outputs(1'b0);
    step(1'b1, 32'h4040_0000, 1'b0, {2'b00, 32'h4110_0000});
    idle(4);
    chk("reset_drained", 35'(q.size()), 35'd0);

    // Random traffic with sporadic stalls.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rx;
      logic        rv;
      logic        rs;
      rx = $urandom;
      rv = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 7) == 0);
      step(rv, rx, rs, model(rx));
    end
    idle(4);
    chk("random_drained", 35'(q.size()), 35'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
